// File: rtl/jtag_vdr_bridge.sv
// jtag_vdr_bridge
//   Bridges a virtual JTAG data register onto two word FIFOs, all in the TCK
//   domain.
//   PUSH   : bits shifted in on tdi (LSB first) are committed on udr into the
//            RX FIFO, which a fabric consumer drains through out_data/out_valid/out_ready.
//   POP    : a word written by the fabric (in_data/in_valid/in_ready) into the
//            TX FIFO is captured on cdr and shifted out on tdo.
//   STATUS : captures {rx_ovf, tx_udf, tx_count, rx_count} and clears the
//            sticky flags.
// Ports
//   tck, reset            clock, synchronous active-high reset
//   tdi, tdo              serial data in / out (tdo combinational)
//   ir_in, cdr, sdr, udr  virtual IR and capture/shift/update-DR strobes
//   out_*                 RX FIFO read side
//   in_*                  TX FIFO write side
//   rx_count, tx_count    FIFO occupancies (0..DEPTH)
//   rx_ovf, tx_udf        sticky overflow / underflow flags
module jtag_vdr_bridge #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CW     = $clog2(DEPTH+1)
) (
  input  logic              tck,
  input  logic              reset,
  input  logic              tdi,
  input  logic [2:0]        ir_in,
  input  logic              cdr,
  input  logic              sdr,
  input  logic              udr,
  output logic              tdo,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CW-1:0]     rx_count,
  output logic [CW-1:0]     tx_count,
  output logic              rx_ovf,
  output logic              tx_udf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] IR_PUSH   = 3'b001;
  localparam logic [2:0] IR_POP    = 3'b010;
  localparam logic [2:0] IR_STATUS = 3'b011;

  logic [DATA_W-1:0] sr_in_q, sr_in_d, sr_out_q, sr_out_d;
  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [AW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic              rx_ovf_q, rx_ovf_d, tx_udf_q, tx_udf_d;

  logic is_push, is_pop, is_stat;
  logic rx_full, rx_wr, rx_rd, rx_ovf_set;
  logic tx_full, tx_empty, tx_wr, tx_pop, tx_udf_set, st_cap;
  logic [DATA_W-1:0] status;

  always_comb begin
    is_push = (ir_in == IR_PUSH);
    is_pop  = (ir_in == IR_POP);
    is_stat = (ir_in == IR_STATUS);

    // Full/empty decisions use pre-edge occupancy only, so a same-edge read
    // never makes room for a commit and a same-edge write never feeds a capture.
    rx_full    = (rx_cnt_q == CW'(DEPTH));
    rx_wr      = udr & is_push & ~rx_full;
    rx_ovf_set = udr & is_push & rx_full;
    out_valid  = (rx_cnt_q != '0);
    rx_rd      = out_valid & out_ready;

    tx_full    = (tx_cnt_q == CW'(DEPTH));
    tx_empty   = (tx_cnt_q == '0);
    in_ready   = ~tx_full;
    tx_wr      = in_valid & in_ready;
    tx_pop     = cdr & is_pop & ~tx_empty;
    tx_udf_set = cdr & is_pop & tx_empty;
    st_cap     = cdr & is_stat;

    status             = '0;
    status[CW-1:0]     = rx_cnt_q;
    status[2*CW-1:CW]  = tx_cnt_q;
    status[2*CW]       = tx_udf_q;
    status[2*CW+1]     = rx_ovf_q;

    sr_in_d = sr_in_q;
    if (sdr && is_push) sr_in_d = {tdi, sr_in_q[DATA_W-1:1]};

    sr_out_d = sr_out_q;
    if (tx_pop)                      sr_out_d = tx_mem_q[tx_rp_q];
    else if (tx_udf_set)             sr_out_d = '0;
    else if (st_cap)                 sr_out_d = status;
    else if (sdr && (is_pop || is_stat)) sr_out_d = {tdi, sr_out_q[DATA_W-1:1]};

    rx_wp_d  = rx_wr ? rx_wp_q + AW'(1) : rx_wp_q;
    rx_rp_d  = rx_rd ? rx_rp_q + AW'(1) : rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_wr && !rx_rd)      rx_cnt_d = rx_cnt_q + CW'(1);
    else if (!rx_wr && rx_rd) rx_cnt_d = rx_cnt_q - CW'(1);

    tx_wp_d  = tx_wr  ? tx_wp_q + AW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop ? tx_rp_q + AW'(1) : tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_wr && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
    else if (!tx_wr && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);

    // STATUS read clears the flags, but a set on the same edge survives.
    rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~st_cap);
    tx_udf_d = tx_udf_set | (tx_udf_q & ~st_cap);
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      sr_in_q  <= '0;
      sr_out_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      rx_ovf_q <= 1'b0;
      tx_udf_q <= 1'b0;
    end else begin
      sr_in_q  <= sr_in_d;
      sr_out_q <= sr_out_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      rx_ovf_q <= rx_ovf_d;
      tx_udf_q <= tx_udf_d;
    end
  end

  // Storage needs no reset: the cleared pointers/counts make old contents
  // unreachable.
  always_ff @(posedge tck) begin
    if (rx_wr) rx_mem_q[rx_wp_q] <= sr_in_q;
    if (tx_wr) tx_mem_q[tx_wp_q] <= in_data;
  end

  always_comb begin
    tdo = tdi;
    if (is_push)               tdo = sr_in_q[0];
    else if (is_pop || is_stat) tdo = sr_out_q[0];
  end

  // Empty FIFO presents zero rather than a stale or uninitialised entry.
  assign out_data = out_valid ? rx_mem_q[rx_rp_q] : '0;
  assign rx_count = rx_cnt_q;
  assign tx_count = tx_cnt_q;
  assign rx_ovf   = rx_ovf_q;
  assign tx_udf   = tx_udf_q;
endmodule

// File: tb/tb_jtag_vdr_bridge.sv
module tb_jtag_vdr_bridge;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH+1);

  logic              tck = 1'b0;
  logic              reset, tdi, cdr, sdr, udr, out_ready, in_valid;
  logic [2:0]        ir_in;
  logic [DATA_W-1:0] in_data;
  logic              tdo, out_valid, in_ready, rx_ovf, tx_udf;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     rx_count, tx_count;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] rxq[$];
  logic [DATA_W-1:0] txq[$];
  logic [DATA_W-1:0] got, exp_w;

  jtag_vdr_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .tck(tck), .reset(reset), .tdi(tdi), .ir_in(ir_in), .cdr(cdr), .sdr(sdr),
    .udr(udr), .tdo(tdo), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rx_count(rx_count), .tx_count(tx_count),
    .rx_ovf(rx_ovf), .tx_udf(tx_udf)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Shift a word LSB first under PUSH, then optionally commit with udr.
  // pop_same also asserts out_ready on the commit edge.
  task automatic push_word(input logic [DATA_W-1:0] w, input bit commit, input bit pop_same);
    for (int i = 0; i < DATA_W; i++) begin
      @(negedge tck); ir_in = 3'b001; sdr = 1'b1; tdi = w[i];
    end
    @(negedge tck); sdr = 1'b0; udr = commit; out_ready = pop_same;
    @(negedge tck); udr = 1'b0; out_ready = 1'b0;
  endtask

  // Capture under the given IR then shift DATA_W bits, collecting tdo.
  task automatic scan_out(input logic [2:0] ir, input bit wr_same,
                          input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] w);
    @(negedge tck); ir_in = ir; cdr = 1'b1; in_valid = wr_same; in_data = wd;
    @(negedge tck); cdr = 1'b0; in_valid = 1'b0; sdr = 1'b1; tdi = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      #1 w[i] = tdo;
      @(negedge tck);
    end
    sdr = 1'b0;
  endtask

  task automatic tx_write(input logic [DATA_W-1:0] w);
    @(negedge tck); in_valid = 1'b1; in_data = w;
    @(negedge tck); in_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag);
    @(negedge tck);
    exp_w = rxq.pop_front();
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_data"}, 64'(out_data), 64'(exp_w));
    out_ready = 1'b1;
    @(negedge tck); out_ready = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] st_word(bit ovf, bit udf, int txc, int rxc);
    logic [DATA_W-1:0] s;
    s = '0;
    s[CW-1:0]    = CW'(rxc);
    s[2*CW-1:CW] = CW'(txc);
    s[2*CW]      = udf;
    s[2*CW+1]    = ovf;
    return s;
  endfunction

  initial begin
    reset = 1'b1; tdi = 1'b0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0; ir_in = 3'b000;
    repeat (2) @(negedge tck);
    reset = 1'b0;
    @(negedge tck);

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_rx_count", 64'(rx_count), 64'(0));
    chk("rst_tx_count", 64'(tx_count), 64'(0));
    chk("rst_flags", 64'({rx_ovf, tx_udf}), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));

    // Single PUSH
    push_word(32'hDEADBEEF, 1'b1, 1'b0); rxq.push_back(32'hDEADBEEF);
    chk("push1_count", 64'(rx_count), 64'(1));
    drain_one("push1");
    @(negedge tck);
    chk("push1_empty", 64'(out_valid), 64'(0));

    // Overflow: 8 fill, 9th dropped, 10th dropped despite same-edge read
    for (int k = 1; k <= 8; k++) begin
      push_word(DATA_W'(k), 1'b1, 1'b0); rxq.push_back(DATA_W'(k));
    end
    chk("full_count", 64'(rx_count), 64'(8));
    chk("full_noovf", 64'(rx_ovf), 64'(0));
    push_word(32'h9, 1'b1, 1'b0);
    chk("ovf_count", 64'(rx_count), 64'(8));
    chk("ovf_flag", 64'(rx_ovf), 64'(1));
    exp_w = rxq.pop_front();
    chk("ovf_head", 64'(out_data), 64'(exp_w));
    push_word(32'hA, 1'b1, 1'b1);
    chk("norescue_count", 64'(rx_count), 64'(7));
    while (rxq.size() > 0) drain_one("drain");
    @(negedge tck);
    chk("drain_count", 64'(rx_count), 64'(0));
    scan_out(3'b011, 1'b0, '0, got);
    chk("status_ovf", 64'(got), 64'(st_word(1, 0, 0, 0)));
    scan_out(3'b011, 1'b0, '0, got);
    chk("status_clr", 64'(got), 64'(st_word(0, 0, 0, 0)));

    // TX path
    tx_write(32'h12345678); txq.push_back(32'h12345678);
    chk("tx1_count", 64'(tx_count), 64'(1));
    scan_out(3'b010, 1'b0, '0, got);
    chk("pop1_data", 64'(got), 64'(txq.pop_front()));
    chk("pop1_count", 64'(tx_count), 64'(0));

    for (int k = 0; k < DEPTH; k++) begin
      tx_write(32'hC0DE0000 + DATA_W'(k * 3)); txq.push_back(32'hC0DE0000 + DATA_W'(k * 3));
    end
    chk("txfull_ready", 64'(in_ready), 64'(0));
    tx_write(32'hBAD0BAD0);
    chk("txfull_count", 64'(tx_count), 64'(8));
    while (txq.size() > 0) begin
      scan_out(3'b010, 1'b0, '0, got);
      chk("pop_order", 64'(got), 64'(txq.pop_front()));
    end
    chk("txdrain_ready", 64'(in_ready), 64'(1));

    // Underflow, and a same-edge write is not returned
    scan_out(3'b010, 1'b0, '0, got);
    chk("udf_data", 64'(got), 64'(0));
    chk("udf_flag", 64'(tx_udf), 64'(1));
    scan_out(3'b011, 1'b0, '0, got);
    chk("status_udf", 64'(got), 64'(st_word(0, 1, 0, 0)));
    scan_out(3'b011, 1'b0, '0, got);
    chk("status_udf_clr", 64'(got), 64'(st_word(0, 0, 0, 0)));
    scan_out(3'b010, 1'b1, 32'h0F0F1234, got); txq.push_back(32'h0F0F1234);
    chk("samecap_data", 64'(got), 64'(0));
    chk("samecap_udf", 64'(tx_udf), 64'(1));
    chk("samecap_count", 64'(tx_count), 64'(1));
    scan_out(3'b010, 1'b0, '0, got);
    chk("samecap_later", 64'(got), 64'(txq.pop_front()));
    scan_out(3'b011, 1'b0, '0, got);
    chk("status_udf2", 64'(got), 64'(st_word(0, 1, 0, 0)));

    // Bypass and non-matching strobes
    push_word(32'h55AA55AA, 1'b1, 1'b0); rxq.push_back(32'h55AA55AA);
    for (int i = 0; i < 8; i++) begin
      @(negedge tck); ir_in = 3'b111; sdr = i[0]; tdi = 1'($urandom_range(0, 1));
      #1 chk("bypass_tdo", 64'(tdo), 64'(tdi));
    end
    @(negedge tck); sdr = 1'b0; ir_in = 3'b011; udr = 1'b1;
    @(negedge tck); ir_in = 3'b001; udr = 1'b0; cdr = 1'b1;
    @(negedge tck); ir_in = 3'b111; cdr = 1'b0; udr = 1'b1;
    @(negedge tck); udr = 1'b0;
    chk("nomatch_rx", 64'(rx_count), 64'(1));
    chk("nomatch_tx", 64'(tx_count), 64'(0));
    chk("nomatch_flags", 64'({rx_ovf, tx_udf}), 64'(0));
    chk("nomatch_head", 64'(out_data), 64'(rxq[0]));

    // Reset mid-shift
    for (int i = 0; i < 10; i++) begin
      @(negedge tck); ir_in = 3'b001; sdr = 1'b1; tdi = i[0];
    end
    @(negedge tck); reset = 1'b1; udr = 1'b1;
    @(negedge tck); reset = 1'b0; udr = 1'b0; sdr = 1'b0;
    rxq.delete();
    chk("midrst_count", 64'(rx_count), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_data", 64'(out_data), 64'(0));
    push_word(32'hABCD1234, 1'b1, 1'b0); rxq.push_back(32'hABCD1234);
    chk("midrst_count2", 64'(rx_count), 64'(1));
    drain_one("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
